// File: rtl/router_rr_param.sv
// router_rr_param: 5-port XY mesh router for single-flit packets.
// Port order everywhere is [core, north, east, south, west].
// Each input has a FIFO followed by an XY route calculator.
// Each output has a round-robin allocator and a one-entry output register.
// Optional feature macro: ROUTER_PERF_CNT_EN adds saturating per-output
// delivered-flit counters on o_flit_cnt.
module router_rr_param #(
    parameter int unsigned X_LOC      = 0,
    parameter int unsigned Y_LOC      = 0,
    parameter int unsigned X_NODES    = 4,
    parameter int unsigned Y_NODES    = 4,
    parameter int unsigned COORD_W    = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4:0][DATA_W-1:0]    i_data,
    input  logic [4:0]                i_data_val,
    output logic [4:0]                o_en,
    output logic [4:0][DATA_W-1:0]    o_data,
    output logic [4:0]                o_data_val,
    input  logic [4:0]                i_en,
    output logic                      o_route_err
`ifdef ROUTER_PERF_CNT_EN
    ,
    output logic [4:0][CNT_W-1:0]     o_flit_cnt
`endif
);

    localparam int unsigned NumPorts  = 5;
    localparam int unsigned PortCore  = 0;
    localparam int unsigned PortNorth = 1;
    localparam int unsigned PortEast  = 2;
    localparam int unsigned PortSouth = 3;
    localparam int unsigned PortWest  = 4;
    localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CntFifoW  = PtrW + 1;
    localparam logic [CntFifoW-1:0] FullCnt = CntFifoW'(FIFO_DEPTH);

    // Input FIFO state
    logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem_q [NumPorts];
    logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem_d [NumPorts];
    logic [PtrW-1:0]                   wr_ptr_q [NumPorts];
    logic [PtrW-1:0]                   wr_ptr_d [NumPorts];
    logic [PtrW-1:0]                   rd_ptr_q [NumPorts];
    logic [PtrW-1:0]                   rd_ptr_d [NumPorts];
    logic [CntFifoW-1:0]               cnt_q [NumPorts];
    logic [CntFifoW-1:0]               cnt_d [NumPorts];
    logic [NumPorts-1:0]               en_q, en_d;
    logic [NumPorts-1:0]               push, pop;

    // Head of each FIFO and its routing request
    logic [DATA_W-1:0]                 head_data [NumPorts];
    logic [COORD_W-1:0]                x_dst [NumPorts];
    logic [COORD_W-1:0]                y_dst [NumPorts];
    logic [NumPorts-1:0]               head_val, head_bad;
    logic [NumPorts-1:0]               req [NumPorts];

    // Allocation
    logic [2:0]                        ptr_q [NumPorts];
    logic [2:0]                        ptr_d [NumPorts];
    logic [NumPorts-1:0]               gnt_any;
    logic [2:0]                        gnt_src [NumPorts];
    logic [2:0]                        cand;

    // Output registers and error flag
    logic [NumPorts-1:0][DATA_W-1:0]   out_data_q, out_data_d;
    logic [NumPorts-1:0]               out_val_q, out_val_d;
    logic                              err_q, err_d;

    // XY route on each valid FIFO head; out-of-range heads raise no request.
    always_comb begin
        head_val = '0;
        head_bad = '0;
        for (int k = 0; k < NumPorts; k++) begin
            head_data[k] = mem_q[k][rd_ptr_q[k]];
            x_dst[k]     = head_data[k][COORD_W-1:0];
            y_dst[k]     = head_data[k][2*COORD_W-1:COORD_W];
            head_val[k]  = (cnt_q[k] != '0);
            head_bad[k]  = head_val[k] &&
                           ((32'(x_dst[k]) >= X_NODES) || (32'(y_dst[k]) >= Y_NODES));
            req[k] = '0;
            if (head_val[k] && !head_bad[k]) begin
                if (32'(x_dst[k]) > X_LOC) begin
                    req[k][PortEast] = 1'b1;
                end else if (32'(x_dst[k]) < X_LOC) begin
                    req[k][PortWest] = 1'b1;
                end else if (32'(y_dst[k]) > Y_LOC) begin
                    req[k][PortSouth] = 1'b1;
                end else if (32'(y_dst[k]) < Y_LOC) begin
                    req[k][PortNorth] = 1'b1;
                end else begin
                    req[k][PortCore] = 1'b1;
                end
            end
        end
    end

    // Round-robin grant per output starting at ptr; bad heads are popped unrequested.
    always_comb begin
        ptr_d   = ptr_q;
        gnt_any = '0;
        gnt_src = '{default: '0};
        pop     = head_bad;
        cand    = '0;
        for (int j = 0; j < NumPorts; j++) begin
            if (!out_val_q[j] || i_en[j]) begin
                for (int unsigned off = 0; off < NumPorts; off++) begin
                    cand = 3'((32'(ptr_q[j]) + off) % NumPorts);
                    if (!gnt_any[j] && req[cand][j]) begin
                        gnt_any[j] = 1'b1;
                        gnt_src[j] = cand;
                    end
                end
                if (gnt_any[j]) begin
                    pop[gnt_src[j]] = 1'b1;
                    ptr_d[j] = (gnt_src[j] == 3'(NumPorts - 1)) ? 3'd0 : gnt_src[j] + 3'd1;
                end
            end
        end
    end

    // FIFO write/read bookkeeping; o_en follows the post-update occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        push     = '0;
        en_d     = '0;
        for (int k = 0; k < NumPorts; k++) begin
            push[k] = i_data_val[k] && en_q[k];
            if (push[k]) begin
                mem_d[k][wr_ptr_q[k]] = i_data[k];
                wr_ptr_d[k] = wr_ptr_q[k] + 1'b1;
            end
            if (pop[k]) begin
                rd_ptr_d[k] = rd_ptr_q[k] + 1'b1;
            end
            if (push[k] && !pop[k]) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end else if (!push[k] && pop[k]) begin
                cnt_d[k] = cnt_q[k] - 1'b1;
            end
            en_d[k] = (cnt_d[k] != FullCnt);
        end
    end

    // Output registers: load on grant, otherwise drain when accepted downstream.
    always_comb begin
        out_data_d = out_data_q;
        out_val_d  = out_val_q;
        err_d      = err_q | (|head_bad);
        for (int j = 0; j < NumPorts; j++) begin
            if (gnt_any[j]) begin
                out_data_d[j] = head_data[gnt_src[j]];
                out_val_d[j]  = 1'b1;
            end else if (out_val_q[j] && i_en[j]) begin
                out_val_d[j]  = 1'b0;
            end
        end
    end

    // FIFO storage carries no reset; occupancy counters define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '{default: '0};
            rd_ptr_q   <= '{default: '0};
            cnt_q      <= '{default: '0};
            en_q       <= '1;
            ptr_q      <= '{default: '0};
            out_data_q <= '0;
            out_val_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            ptr_q      <= ptr_d;
            out_data_q <= out_data_d;
            out_val_q  <= out_val_d;
            err_q      <= err_d;
        end
    end

    assign o_en        = en_q;
    assign o_data      = out_data_q;
    assign o_data_val  = out_val_q;
    assign o_route_err = err_q;

`ifdef ROUTER_PERF_CNT_EN
    logic [NumPorts-1:0][CNT_W-1:0] flit_cnt_q, flit_cnt_d;

    // Count deliveries per output, saturating instead of wrapping.
    always_comb begin
        flit_cnt_d = flit_cnt_q;
        for (int j = 0; j < NumPorts; j++) begin
            if (out_val_q[j] && i_en[j] && (flit_cnt_q[j] != {CNT_W{1'b1}})) begin
                flit_cnt_d[j] = flit_cnt_q[j] + 1'b1;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            flit_cnt_q <= '0;
        end else begin
            flit_cnt_q <= flit_cnt_d;
        end
    end

    assign o_flit_cnt = flit_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W != 0);
`endif

endmodule
